// File: rtl/sort_calc_seq_if.sv
// Sample/result handshake bundle for sort_calc_seq.
interface sort_calc_seq_if #(
  parameter int W  = 4,
  parameter int OW = 10
);
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [2:0]    opt;
  logic          equ;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] out_data;

  modport master (output in_valid, in_data, opt, equ, input busy, out_valid, out_data);
  modport slave  (input in_valid, in_data, opt, equ, output busy, out_valid, out_data);
endinterface

// File: rtl/sort_calc_seq.sv
// Serial-load odd-even transposition sorter with normalise/running-average transform and equation evaluation.
// Define SORT_CALC_SAT_EN to saturate the result to OW bits instead of wrapping.
//   state  | meaning
//   IDLE   | waiting for first sample
//   LOAD   | collecting samples 1..N-1
//   SORT   | N odd-even transposition passes
//   XFORM  | N-1 transform steps, one element per cycle
//   CALC   | evaluate equation, register result
module sort_calc_seq #(
  parameter int N  = 6,
  parameter int W  = 4,
  parameter int OW = 10
) (
  input  logic            clk,
  input  logic            rst,
  sort_calc_seq_if.slave  io_bus
);

  localparam int MW   = W + 3;
  localparam int CW   = 2 * MW + 4;
  localparam int CNTW = $clog2(N);
  localparam logic [CNTW-1:0] LAST_S = CNTW'(N - 1);
  localparam logic [CNTW-1:0] LAST_X = CNTW'(N - 2);
  localparam logic signed [CW-1:0]   C3 = CW'(3);
  localparam logic signed [CW-1:0]   C4 = CW'(4);
  localparam logic signed [MW+1:0]   D3 = (MW+2)'(3);
  localparam logic signed [CW-1:0]   SAT_HI = CW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [CW-1:0]   SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_XFORM, S_CALC} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNTW-1:0]       r_cnt;
  logic [2:0]            r_opt;
  logic                  r_equ;
  logic signed [W:0]     r_buf [N];
  logic signed [MW-1:0]  r_m   [N];
  logic                  r_out_valid;
  logic [OW-1:0]         r_out_data;

  logic                  w_accept;
  logic                  w_sgn;
  logic signed [W:0]     w_ext;
  logic signed [W:0]     w_pass [N];
  logic [CNTW-1:0]       w_xi;
  logic signed [MW+1:0]  w_num;
  logic signed [MW+1:0]  w_avg;
  logic signed [MW-1:0]  w_mnew;
  logic signed [CW-1:0]  w_m0, w_m1, w_m3, w_m4, w_m5;
  logic signed [CW-1:0]  w_eq0, w_dif, w_prd, w_eq1, w_res;
  logic [OW-1:0]         w_out;

  // a sample offered during the out_valid cycle is still treated as busy
  assign w_accept = io_bus.in_valid &&
                    (((r_state == S_IDLE) && !r_out_valid) || (r_state == S_LOAD));
  assign w_sgn    = (r_state == S_IDLE) ? io_bus.opt[0] : r_opt[0];
  assign w_ext    = w_sgn ? {io_bus.in_data[W-1], io_bus.in_data} : {1'b0, io_bus.in_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && (r_cnt == LAST_S)) w_state_nxt = S_SORT;
      S_SORT:  if (r_cnt == LAST_S) w_state_nxt = S_XFORM;
      S_XFORM: if (r_cnt == LAST_X) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pass = r_buf;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == r_cnt[0]) begin
        if (r_opt[1] ? (r_buf[i] < r_buf[i+1]) : (r_buf[i] > r_buf[i+1])) begin
          w_pass[i]   = r_buf[i+1];
          w_pass[i+1] = r_buf[i];
        end
      end
    end
  end

  assign w_xi   = r_cnt + 1'b1;
  assign w_num  = ((MW+2)'(r_m[r_cnt]) <<< 1) + (MW+2)'(r_buf[w_xi]);
  assign w_avg  = w_num / D3;
  assign w_mnew = r_opt[2] ? MW'(w_avg) : (MW'(r_buf[w_xi]) - MW'(r_buf[0]));

  assign w_m0  = CW'(r_m[0]);
  assign w_m1  = CW'(r_m[1]);
  assign w_m3  = CW'(r_m[N-3]);
  assign w_m4  = CW'(r_m[N-2]);
  assign w_m5  = CW'(r_m[N-1]);
  assign w_eq0 = ((w_m3 + C4 * w_m4) * w_m5) / C3;
  assign w_dif = w_m1 - w_m0;
  assign w_prd = w_dif * w_m5;
  assign w_eq1 = w_prd[CW-1] ? -w_prd : w_prd;
  assign w_res = r_equ ? w_eq1 : w_eq0;

`ifdef SORT_CALC_SAT_EN
  assign w_out = (w_res > SAT_HI) ? SAT_HI[OW-1:0] :
                 (w_res < SAT_LO) ? SAT_LO[OW-1:0] : w_res[OW-1:0];
`else
  assign w_out = w_res[OW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_opt       <= '0;
      r_equ       <= 1'b0;
      r_buf       <= '{default: '0};
      r_m         <= '{default: '0};
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf[0] <= w_ext;
            r_opt    <= io_bus.opt;
            r_equ    <= io_bus.equ;
            r_cnt    <= CNTW'(1);
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_buf[r_cnt] <= w_ext;
            r_cnt        <= (r_cnt == LAST_S) ? '0 : r_cnt + 1'b1;
          end
        end
        S_SORT: begin
          r_buf <= w_pass;
          if (r_cnt == LAST_S) begin
            r_cnt  <= '0;
            r_m[0] <= r_opt[2] ? MW'(w_pass[0]) : '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_XFORM: begin
          r_m[w_xi] <= w_mnew;
          r_cnt     <= (r_cnt == LAST_X) ? '0 : r_cnt + 1'b1;
        end
        S_CALC: begin
          r_out_data  <= w_out;
          r_out_valid <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign io_bus.busy      = (r_state != S_IDLE) || r_out_valid;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;

endmodule
